// File: rtl/cache_way_ctrl_if.sv
// Bundle between the 2-way cache controller, its two tag banks, the tag mux,
// the refill path and the requester.
interface cache_way_ctrl_if #(
  parameter int K     = 14,
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx;
  logic [K-1:0]     req_tag;
  logic             flush;
  logic [IDX_W-1:0] tag_rd_idx;
  logic [K-1:0]     tag1_q;
  logic [K-1:0]     tag2_q;
  logic             tag_we1;
  logic             tag_we2;
  logic [IDX_W-1:0] tag_wr_idx;
  logic [K-1:0]     tag_wr_data;
  logic             way_sel;
  logic             refill_req;
  logic             refill_ack;
  logic             resp_valid;
  logic             resp_hit;
  logic             resp_way;

  // controller side
  modport slave (
    input  req_valid, req_idx, req_tag, flush, tag1_q, tag2_q, refill_ack,
    output req_ready, tag_rd_idx, tag_we1, tag_we2, tag_wr_idx, tag_wr_data,
           way_sel, refill_req, resp_valid, resp_hit, resp_way
  );

  // requester / memory side
  modport master (
    output req_valid, req_idx, req_tag, flush, tag1_q, tag2_q, refill_ack,
    input  req_ready, tag_rd_idx, tag_we1, tag_we2, tag_wr_idx, tag_wr_data,
           way_sel, refill_req, resp_valid, resp_hit, resp_way
  );
endinterface

// File: rtl/cache_way_ctrl.sv
// Two-way set-associative tag lookup controller. Holds per-set valid and LRU
// bits; tags live in two external registered banks read one cycle ahead.
module cache_way_ctrl #(
  parameter int K     = 14,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  cache_way_ctrl_if.slave  bus
);
  localparam int SETS = 1 << IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic [K-1:0]     tag_q;
  logic             way_q;
  logic             hit_q;
  logic [SETS-1:0]  valid1;
  logic [SETS-1:0]  valid2;
  logic [SETS-1:0]  lru;

  logic accept;
  logic hit1, hit2, victim;
  logic upd;

  // lookup compare and victim pick against the latched set
  always_comb begin
    hit1   = valid1[idx_q] && (bus.tag1_q == tag_q);
    hit2   = valid2[idx_q] && (bus.tag2_q == tag_q);
    victim = !valid1[idx_q] ? 1'b0 :
             !valid2[idx_q] ? 1'b1 : lru[idx_q];
  end

  // outputs decode from state; everything forced low while rst is high
  always_comb begin
    bus.req_ready   = !rst && (state == S_IDLE) && !bus.flush;
    accept          = bus.req_valid && bus.req_ready;
    upd             = !rst && (state == S_UPDATE);
    bus.tag_rd_idx  = rst ? '0 : (accept ? bus.req_idx : idx_q);
    bus.tag_we1     = upd && !way_q;
    bus.tag_we2     = upd && way_q;
    bus.tag_wr_idx  = upd ? idx_q : '0;
    bus.tag_wr_data = upd ? tag_q : '0;
    bus.way_sel     = !rst && way_q &&
                      ((state == S_REFILL) || (state == S_UPDATE) || (state == S_RESP));
    bus.refill_req  = !rst && (state == S_REFILL);
    bus.resp_valid  = !rst && (state == S_RESP);
    bus.resp_hit    = bus.resp_valid && hit_q;
    bus.resp_way    = bus.resp_valid && way_q;
  end

  // FSM plus valid/LRU bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      tag_q  <= '0;
      way_q  <= 1'b0;
      hit_q  <= 1'b0;
      valid1 <= '0;
      valid2 <= '0;
      lru    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            valid1 <= '0;
            valid2 <= '0;
            lru    <= '0;
          end else if (accept) begin
            idx_q <= bus.req_idx;
            tag_q <= bus.req_tag;
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit1 || hit2) begin
            // way 0 wins a double hit; the other way becomes LRU
            way_q      <= !hit1;
            hit_q      <= 1'b1;
            lru[idx_q] <= hit1;
            state      <= S_RESP;
          end else begin
            way_q <= victim;
            hit_q <= 1'b0;
            state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.refill_ack) state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (way_q) valid2[idx_q] <= 1'b1;
          else       valid1[idx_q] <= 1'b1;
          lru[idx_q] <= !way_q;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: behavioural tag banks, a set/way reference model,
// directed vector table, hand sequences and randomized traffic.
module tb_cache_way_ctrl;
  localparam int K     = 14;
  localparam int IDX_W = 4;
  localparam int SETS  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp, n_bad;

  cache_way_ctrl_if #(.K(K), .IDX_W(IDX_W)) bus ();
  cache_way_ctrl #(.K(K), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // registered tag banks
  logic [K-1:0] bank1 [SETS];
  logic [K-1:0] bank2 [SETS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        bank1[i] <= '0;
        bank2[i] <= '0;
      end
    end else begin
      if (bus.tag_we1) bank1[bus.tag_wr_idx] <= bus.tag_wr_data;
      if (bus.tag_we2) bank2[bus.tag_wr_idx] <= bus.tag_wr_data;
    end
    bus.tag1_q <= bank1[bus.tag_rd_idx];
    bus.tag2_q <= bank2[bus.tag_rd_idx];
  end

  // reference cache model: tag/valid per (way,set), LRU way per set
  logic [K-1:0] m_tag [2][SETS];
  bit           m_vld [2][SETS];
  bit           m_lru [SETS];

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_vld[0][s] = 0; m_vld[1][s] = 0; m_lru[s] = 0;
    end
  endtask

  task automatic m_access(input int idx, input logic [K-1:0] tag,
                          output bit hit, output bit way);
    if (m_vld[0][idx] && m_tag[0][idx] == tag) begin
      hit = 1; way = 0;
    end else if (m_vld[1][idx] && m_tag[1][idx] == tag) begin
      hit = 1; way = 1;
    end else begin
      hit = 0;
      if (!m_vld[0][idx])      way = 0;
      else if (!m_vld[1][idx]) way = 1;
      else                     way = m_lru[idx];
      m_tag[way][idx] = tag;
      m_vld[way][idx] = 1;
    end
    m_lru[idx] = !way;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_we1"}, bus.tag_we1, 0);
    chk({nm, "_we2"}, bus.tag_we2, 0);
    chk({nm, "_refill"}, bus.refill_req, 0);
    chk({nm, "_resp"}, bus.resp_valid, 0);
  endtask

  // one request from acceptance to response; call just after a negedge
  task automatic run_req(input logic [IDX_W-1:0] idx, input logic [K-1:0] tag,
                         input int ack_dly, input bit stray, input bit exp_hit,
                         input bit exp_way, input bit nxt_v,
                         input logic [IDX_W-1:0] nidx, input logic [K-1:0] ntag);
    int ref_first = -1, ref_n = 0, ack_cyc = -100, we_n = 0, we_cyc = -1, resp_cyc = -1;
    bit we_w = 0, sel_we = 0, r_hit = 0, r_way = 0, sel_resp = 0;
    logic [IDX_W-1:0] wi = '0;
    logic [K-1:0] wd = '0;
    bus.req_valid  = 1; bus.req_idx = idx; bus.req_tag = tag;
    bus.refill_ack = stray;
    #1;
    chk("req_ready_acc", bus.req_ready, 1);
    chk("rd_idx_acc", bus.tag_rd_idx, idx);
    chk("way_sel_idle", bus.way_sel, 0);
    @(negedge clk);
    if (nxt_v) begin bus.req_idx = nidx; bus.req_tag = ntag; end
    else bus.req_valid = 0;
    bus.refill_ack = 0;
    for (int cyc = 1; cyc < 40 && resp_cyc < 0; cyc++) begin
      #1;
      if (nxt_v) chk("ready_busy", bus.req_ready, 0);
      chk("rd_idx_hold", bus.tag_rd_idx, idx);
      if (bus.refill_req) begin
        if (ref_first < 0) ref_first = cyc;
        ref_n++;
        if (ref_n == ack_dly + 1) begin bus.refill_ack = 1; ack_cyc = cyc; end
      end
      if (bus.tag_we1 || bus.tag_we2) begin
        we_n += (bus.tag_we1 && bus.tag_we2) ? 2 : 1;
        we_cyc = cyc; we_w = bus.tag_we2; wi = bus.tag_wr_idx; wd = bus.tag_wr_data;
        sel_we = bus.way_sel;
      end
      if (bus.resp_valid) begin
        resp_cyc = cyc; r_hit = bus.resp_hit; r_way = bus.resp_way; sel_resp = bus.way_sel;
      end
      @(negedge clk);
      bus.refill_ack = 0;
    end
    chk("resp_seen", resp_cyc >= 0, 1);
    chk("resp_hit", r_hit, exp_hit);
    chk("resp_way", r_way, exp_way);
    chk("sel_resp", sel_resp, exp_way);
    if (exp_hit) begin
      chk("hit_latency", resp_cyc, 2);
      chk("hit_no_refill", ref_n, 0);
      chk("hit_no_we", we_n, 0);
    end else begin
      chk("refill_start", ref_first, 2);
      chk("refill_len", ref_n, ack_dly + 1);
      chk("we_count", we_n, 1);
      chk("we_way", we_w, exp_way);
      chk("we_cycle", we_cyc, ack_cyc + 1);
      chk("wr_idx", wi, idx);
      chk("wr_data", wd, tag);
      chk("sel_we", sel_we, exp_way);
      chk("miss_latency", resp_cyc, ack_cyc + 2);
    end
  endtask

  task automatic do_flush();
    bus.flush = 1; bus.req_valid = 1; bus.req_idx = 4'd3; bus.req_tag = 14'h0ABC;
    #1;
    chk("flush_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.flush = 0; bus.req_valid = 0;
    #1;
    chk("post_flush_ready", bus.req_ready, 1);
    @(negedge clk);
    m_clear();
  endtask

  typedef struct {
    bit               fl;
    logic [IDX_W-1:0] idx;
    logic [K-1:0]     tag;
    int               ack;
    bit               hit;
    bit               way;
  } vec_t;

  vec_t         tbl [10];
  logic [K-1:0] pool [4];

  initial begin
    bit ph, pw, dh, dw;
    n_cmp = 0; n_bad = 0;
    rst = 1;
    bus.req_valid = 0; bus.req_idx = '0; bus.req_tag = '0;
    bus.flush = 0; bus.refill_ack = 0;

    tbl[0] = '{0, 4'd3,  14'h0ABC, 2, 0, 0};  // cold miss, ack on cycle 4
    tbl[1] = '{0, 4'd3,  14'h0ABC, 0, 1, 0};  // hit way 0
    tbl[2] = '{0, 4'd3,  14'h1111, 1, 0, 1};  // fill empty way 1
    tbl[3] = '{0, 4'd3,  14'h2222, 0, 0, 0};  // both valid, lru=0 -> way 0
    tbl[4] = '{0, 4'd3,  14'h1111, 0, 1, 1};  // hit way 1
    tbl[5] = '{0, 4'd3,  14'h0ABC, 3, 0, 0};  // evicted earlier, lru=0
    tbl[6] = '{1, 4'd3,  14'h0ABC, 0, 0, 0};  // after flush: miss into way 0
    tbl[7] = '{0, 4'd5,  14'h3FFF, 0, 0, 0};  // all-ones tag
    tbl[8] = '{0, 4'd15, 14'h0000, 1, 0, 0};  // zero tag matches reset bank, still invalid
    tbl[9] = '{0, 4'd15, 14'h0000, 0, 1, 0};
    pool[0] = 14'h0001; pool[1] = 14'h2AAA; pool[2] = 14'h1555; pool[3] = 14'h3FFF;

    // reset state: outputs low even with a request present
    @(negedge clk);
    bus.req_valid = 1; bus.req_idx = 4'd9;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rd_idx", bus.tag_rd_idx, 0);
    chk("rst_way_sel", bus.way_sel, 0);
    chk("rst_resp_hit", bus.resp_hit, 0);
    chk_quiet("rst");
    @(negedge clk);
    bus.req_valid = 0; rst = 0;
    #1;
    chk("rel_ready", bus.req_ready, 1);
    @(negedge clk);
    m_clear();

    // directed table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].fl) do_flush();
      run_req(tbl[i].idx, tbl[i].tag, tbl[i].ack, 0, tbl[i].hit, tbl[i].way, 0, '0, '0);
      m_access(tbl[i].idx, tbl[i].tag, ph, pw);
    end

    // reset during the second refill cycle
    bus.req_valid = 1; bus.req_idx = 4'd7; bus.req_tag = 14'h1234;
    @(negedge clk); bus.req_valid = 0;
    @(negedge clk); #1 chk("mid_refill_req", bus.refill_req, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); #1
    chk("abort_ready", bus.req_ready, 0);
    chk_quiet("abort");
    @(negedge clk); rst = 0;
    #1 chk("abort_rel_ready", bus.req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1 chk_quiet("abort_after");
    end
    @(negedge clk);
    m_clear();
    m_access(3, 14'h0ABC, ph, pw);
    run_req(4'd3, 14'h0ABC, 1, 0, ph, pw, 0, '0, '0);

    // backpressure: second request waits until after RESP
    m_access(9, 14'h2DEF, ph, pw);
    run_req(4'd9, 14'h2DEF, 1, 0, ph, pw, 1, 4'd9, 14'h2DEF);
    m_access(9, 14'h2DEF, ph, pw);
    run_req(4'd9, 14'h2DEF, 0, 0, ph, pw, 0, '0, '0);

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic [IDX_W-1:0] ri;
      logic [K-1:0]     rt;
      if ($urandom_range(0, 15) == 0) do_flush();
      ri = ($urandom_range(0, 7) == 0) ? IDX_W'($urandom_range(0, SETS - 1))
                                       : IDX_W'($urandom_range(0, 3));
      rt = pool[$urandom_range(0, 3)];
      m_access(ri, rt, dh, dw);
      run_req(ri, rt, $urandom_range(0, 3), $urandom_range(0, 3) == 0, dh, dw, 0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_way_ctrl.md
CACHE_WAY_CTRL -- requirements
Module: cache_way_ctrl

Interface
REQ-001 SHALL have parameter K, default 14: tag width in bits, equal to the tag bank and tag mux width.
REQ-002 SHALL have parameter IDX_W, default 4: set index width, giving 2**IDX_W sets.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: lookup request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-007 SHALL have ports req_idx (input, IDX_W) and req_tag (input, K): request set index and tag.
REQ-008 SHALL have port flush, input, 1 bit: invalidate all ways; sampled only in IDLE.
REQ-009 SHALL have port tag_rd_idx, output, IDX_W: read index to both tag banks; bank data is returned one cycle later.
REQ-010 SHALL have ports tag1_q and tag2_q, input, K each: registered read data from tag bank 1 and tag bank 2.
REQ-011 SHALL have ports tag_we1 and tag_we2 (output, 1 each), tag_wr_idx (output, IDX_W) and tag_wr_data (output, K): tag bank write controls.
REQ-012 SHALL have port way_sel, output, 1 bit: drives the SEL input of the 2:1 tag mux; 0 selects bank 1, 1 selects bank 2.
REQ-013 SHALL have ports refill_req (output, 1) and refill_ack (input, 1): line refill handshake with memory.
REQ-014 SHALL have ports resp_valid, resp_hit and resp_way, output, 1 bit each: lookup result.

Function
REQ-015 SHALL implement FSM states IDLE, LOOKUP, REFILL, UPDATE and RESP, and SHALL keep internal arrays valid1, valid2 and lru, each 2**IDX_W bits; lru[i] names the least-recently-used way of set i.
REQ-016 SHALL drive req_ready = 1 only in IDLE with flush = 0.
REQ-017 In IDLE with flush = 1, SHALL clear every valid1, valid2 and lru bit in one cycle, remain in IDLE, and ignore req_valid.
REQ-018 In IDLE on req_valid && req_ready, SHALL latch idx and tag, drive tag_rd_idx = req_idx in that same cycle, and go to LOOKUP.
REQ-019 SHALL hold tag_rd_idx at the latched idx from LOOKUP until the next request is accepted.
REQ-020 In LOOKUP, SHALL compute hit1 = valid1[idx] && tag1_q == tag and hit2 = valid2[idx] && tag2_q == tag.
REQ-021 On any hit, SHALL register way = 0 if hit1, else way = 1 (way 0 wins when both ways hit), set lru[idx] = !way, and go to RESP with hit = 1.
REQ-022 On a miss, SHALL select the victim as: way 0 if !valid1[idx], else way 1 if !valid2[idx], else lru[idx]; SHALL register it as way and go to REFILL.
REQ-023 In REFILL, SHALL hold refill_req = 1 until a cycle in which refill_ack = 1, then go to UPDATE; refill_ack outside REFILL SHALL be ignored.
REQ-024 In UPDATE (one cycle), SHALL assert exactly one of tag_we1 (way 0) or tag_we2 (way 1), with tag_wr_idx = idx and tag_wr_data = tag.
REQ-025 In UPDATE, SHALL set the valid bit of the chosen way at idx, set lru[idx] = !way, and go to RESP with hit = 0.
REQ-026 In RESP (one cycle), SHALL pulse resp_valid = 1 with resp_hit and resp_way equal to the registered values, then return to IDLE.
REQ-027 SHALL drive way_sel = registered way in REFILL, UPDATE and RESP, and way_sel = 0 otherwise.
REQ-028 Latency SHALL be: hit, resp_valid 2 cycles after acceptance; miss, resp_valid 2 cycles after the refill_ack cycle.
REQ-029 Outside the states named above, tag_we1, tag_we2, refill_req and resp_valid SHALL be 0.

Reset
REQ-030 While rst = 1, the block SHALL set state = IDLE, clear all valid and lru bits, and drive every output to 0, including req_ready = 0.
REQ-031 Reset asserted in any state, including mid-REFILL, SHALL abandon the operation with no tag write and no response; req_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-032 Cold miss: after reset, request idx=3, tag=0x0ABC accepted at cycle 0, refill_ack at cycle 4 -> refill_req high cycles 2-4; tag_we1=1, tag_wr_idx=3, tag_wr_data=0x0ABC at cycle 5; resp_valid at cycle 6 with resp_hit=0, resp_way=0.
REQ-033 Hit: repeat idx=3, tag=0x0ABC with tag1_q=0x0ABC -> resp_valid at cycle 2 with resp_hit=1, resp_way=0, and no refill_req.
REQ-034 Replacement: idx=3 tag=0x1111 misses into way 1 (tag_we2); then tag=0x2222 misses with both ways valid and lru=0 -> tag_we1 asserted, way_sel=0.
REQ-035 Flush: flush=1 in IDLE, then idx=3 tag=0x0ABC with tag1_q=0x0ABC -> miss (resp_hit=0), victim way 0.
REQ-036 Reset mid-refill: rst=1 in the second REFILL cycle -> refill_req=0 the next cycle, no tag_we pulse, no resp_valid, req_ready=1 after release.
REQ-037 Backpressure: req_valid held high during a miss -> second request accepted only in the cycle after RESP, with its idx and tag latched at that cycle.
